pad_in_debounce: RTL and testbench

PAD_IN_DEBOUNCE -- requirements
Module: pad_in_debounce

---
 rtl/pad_ctrl_pkg.sv | 20 ++
 rtl/pad_sync.sv | 29 ++
 rtl/pad_in_debounce.sv | 126 ++++++++++++
 tb/tb_pad_in_debounce.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pad_ctrl_pkg : shared debounce FSM states, glitch-counter width and helper
// Revision 1.0
// ---------------------------------------------------------------------------
package pad_ctrl_pkg;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } dbnc_state_e;

  localparam int GLITCH_W = 16;

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (&v) ? v : v + GLITCH_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pad_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pad_sync : multi-flop synchronizer for an asynchronous pad input (2..4 stages)
// Revision 1.0
// ---------------------------------------------------------------------------
module pad_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pad_in_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pad_in_debounce : synchronize, qualify and edge-detect a pad receive value
// Revision 1.0
// ---------------------------------------------------------------------------
module pad_in_debounce
  import pad_ctrl_pkg::*;
#(
  parameter int   CNT_W       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pad_in_i,
  input  logic                pad_oen_i,
  input  logic                en_i,
  input  logic [CNT_W-1:0]    thresh_i,
  input  logic                glitch_clr_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                busy_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  logic                s;
  dbnc_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  pad_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_LEVEL(RESET_LEVEL)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (pad_in_i),
    .q_o  (s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    // A disabled filter, or a pad we are driving ourselves, must not qualify.
    if (!en_i || !pad_oen_i) begin
      state_d = STABLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        STABLE: begin
          if (s != level_q) begin
            if (thresh_i == '0) begin
              level_d = s;
              rise_d  = s;
              fall_d  = ~s;
            end else begin
              state_d = QUALIFY;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        QUALIFY: begin
          if (s == level_q) begin
            state_d  = STABLE;
            cnt_d    = '0;
            glitch_d = sat_inc(glitch_q);
          end else if (cnt_q >= thresh_i) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (glitch_clr_i) begin
      glitch_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= (state_d == QUALIFY);
      glitch_q <= glitch_d;
    end
  end

  assign level_o      = level_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign busy_o       = busy_q;
  assign glitch_cnt_o = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_in_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pad_in_debounce : vector table with scoreboard plus hand-written corners
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pad_in_debounce;

  typedef struct packed {
    logic        pad;
    logic        oen;
    logic        en;
    logic [7:0]  thr;
    logic        clr;
    logic        lvl;
    logic        rise;
    logic        fall;
    logic        busy;
    logic [15:0] gl;
  } vec_t;

  localparam int NV = 42;

  logic        clk = 1'b0;
  logic        rst;
  logic        pad_in;
  logic        pad_oen;
  logic        en;
  logic [7:0]  thresh;
  logic        glitch_clr;
  logic        level;
  logic        rise;
  logic        fall;
  logic        busy;
  logic [15:0] glitch_cnt;

  int total = 0;
  int bad   = 0;

  vec_t tbl [NV];
  vec_t exp_q [$];

  pad_in_debounce dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pad_in_i    (pad_in),
    .pad_oen_i   (pad_oen),
    .en_i        (en),
    .thresh_i    (thresh),
    .glitch_clr_i(glitch_clr),
    .level_o     (level),
    .rise_o      (rise),
    .fall_o      (fall),
    .busy_o      (busy),
    .glitch_cnt_o(glitch_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic p, input logic o, input logic e, input int t,
                             input logic c, input logic l, input logic r, input logic f,
                             input logic b, input int g);
    vec_t x;
    x.pad = p; x.oen = o; x.en = e; x.thr = 8'(t); x.clr = c;
    x.lvl = l; x.rise = r; x.fall = f; x.busy = b; x.gl = 16'(g);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic cmp(input vec_t e, input string tag);
    chk({tag, " level"}, 32'(level), 32'(e.lvl));
    chk({tag, " rise"},  32'(rise),  32'(e.rise));
    chk({tag, " fall"},  32'(fall),  32'(e.fall));
    chk({tag, " busy"},  32'(busy),  32'(e.busy));
    chk({tag, " glitch"}, 32'(glitch_cnt), 32'(e.gl));
  endtask

  // One-cycle low glitch on a high level with thresh=1; it is counted on the 4th edge.
  task automatic glitch_pulse(input logic clr_on_glitch);
    pad_in = 1'b0;
    step(1);
    pad_in = 1'b1;
    step(2);
    glitch_clr = clr_on_glitch;
    step(1);
    glitch_clr = 1'b0;
  endtask

  initial begin
    //          pad oen en thr clr  lvl rise fall busy gl
    // thresh=3: rise after 4 differing s-cycles, then a 2-cycle low glitch
    tbl[0]  = v(1, 1, 1, 3, 0,  0, 0, 0, 0, 0);
    tbl[1]  = v(1, 1, 1, 3, 0,  0, 0, 0, 0, 0);
    tbl[2]  = v(1, 1, 1, 3, 0,  0, 0, 0, 1, 0);
    tbl[3]  = v(1, 1, 1, 3, 0,  0, 0, 0, 1, 0);
    tbl[4]  = v(1, 1, 1, 3, 0,  0, 0, 0, 1, 0);
    tbl[5]  = v(1, 1, 1, 3, 0,  1, 1, 0, 0, 0);
    tbl[6]  = v(1, 1, 1, 3, 0,  1, 0, 0, 0, 0);
    tbl[7]  = v(0, 1, 1, 3, 0,  1, 0, 0, 0, 0);
    tbl[8]  = v(0, 1, 1, 3, 0,  1, 0, 0, 0, 0);
    tbl[9]  = v(1, 1, 1, 3, 0,  1, 0, 0, 1, 0);
    tbl[10] = v(1, 1, 1, 3, 0,  1, 0, 0, 1, 0);
    tbl[11] = v(1, 1, 1, 3, 0,  1, 0, 0, 0, 1);
    tbl[12] = v(1, 1, 1, 3, 0,  1, 0, 0, 0, 1);
    // thresh=1 fall, then glitch clear
    tbl[13] = v(0, 1, 1, 1, 0,  1, 0, 0, 0, 1);
    tbl[14] = v(0, 1, 1, 1, 0,  1, 0, 0, 0, 1);
    tbl[15] = v(0, 1, 1, 1, 0,  1, 0, 0, 1, 1);
    tbl[16] = v(0, 1, 1, 1, 0,  0, 0, 1, 0, 1);
    tbl[17] = v(0, 1, 1, 1, 0,  0, 0, 0, 0, 1);
    tbl[18] = v(0, 1, 1, 1, 1,  0, 0, 0, 0, 0);
    // thresh=0 bypass, pad toggled every 4 cycles
    tbl[19] = v(1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[20] = v(1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[21] = v(1, 1, 1, 0, 0,  1, 1, 0, 0, 0);
    tbl[22] = v(1, 1, 1, 0, 0,  1, 0, 0, 0, 0);
    tbl[23] = v(0, 1, 1, 0, 0,  1, 0, 0, 0, 0);
    tbl[24] = v(0, 1, 1, 0, 0,  1, 0, 0, 0, 0);
    tbl[25] = v(0, 1, 1, 0, 0,  0, 0, 1, 0, 0);
    tbl[26] = v(0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    // pad driven (oen=0) while pad toggles, then requalify with thresh=2
    tbl[27] = v(1, 0, 1, 2, 0,  0, 0, 0, 0, 0);
    tbl[28] = v(0, 0, 1, 2, 0,  0, 0, 0, 0, 0);
    tbl[29] = v(1, 0, 1, 2, 0,  0, 0, 0, 0, 0);
    tbl[30] = v(1, 0, 1, 2, 0,  0, 0, 0, 0, 0);
    tbl[31] = v(1, 1, 1, 2, 0,  0, 0, 0, 1, 0);
    tbl[32] = v(1, 1, 1, 2, 0,  0, 0, 0, 1, 0);
    tbl[33] = v(1, 1, 1, 2, 0,  1, 1, 0, 0, 0);
    tbl[34] = v(1, 1, 1, 2, 0,  1, 0, 0, 0, 0);
    // en dropped mid-qualify: no glitch, restart from cnt=1
    tbl[35] = v(0, 1, 1, 2, 0,  1, 0, 0, 0, 0);
    tbl[36] = v(0, 1, 1, 2, 0,  1, 0, 0, 0, 0);
    tbl[37] = v(0, 1, 1, 2, 0,  1, 0, 0, 1, 0);
    tbl[38] = v(0, 1, 0, 2, 0,  1, 0, 0, 0, 0);
    tbl[39] = v(0, 1, 1, 2, 0,  1, 0, 0, 1, 0);
    tbl[40] = v(0, 1, 1, 2, 0,  1, 0, 0, 1, 0);
    tbl[41] = v(0, 1, 1, 2, 0,  0, 0, 1, 0, 0);

    rst = 1'b1; pad_in = 1'b0; pad_oen = 1'b1; en = 1'b1; thresh = 8'd0; glitch_clr = 1'b0;
    step(3);
    cmp(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      pad_in = tbl[i].pad; pad_oen = tbl[i].oen; en = tbl[i].en;
      thresh = tbl[i].thr; glitch_clr = tbl[i].clr;
      exp_q.push_back(tbl[i]);
      step(1);
      cmp(exp_q.pop_front(), $sformatf("row%0d", i + 1));
    end

    // thresh lowered from 10 to 2 once cnt reaches 5
    pad_in = 1'b1; thresh = 8'd10; pad_oen = 1'b1; en = 1'b1; glitch_clr = 1'b0;
    step(7);
    chk("thrdrop busy", 32'(busy), 32'd1);
    chk("thrdrop level_pre", 32'(level), 32'd0);
    thresh = 8'd2;
    step(1);
    chk("thrdrop level", 32'(level), 32'd1);
    chk("thrdrop rise", 32'(rise), 32'd1);
    step(1);
    chk("thrdrop rise_end", 32'(rise), 32'd0);

    // saturation and clear-wins-over-glitch
    thresh = 8'd1;
    force dut.glitch_q = 16'hFFFE;
    #1;
    release dut.glitch_q;
    chk("sat preload", 32'(glitch_cnt), 32'h0000FFFE);
    glitch_pulse(1'b0);
    chk("sat reach", 32'(glitch_cnt), 32'h0000FFFF);
    glitch_pulse(1'b0);
    chk("sat hold", 32'(glitch_cnt), 32'h0000FFFF);
    chk("sat level", 32'(level), 32'd1);
    glitch_pulse(1'b1);
    chk("clr wins", 32'(glitch_cnt), 32'd0);
    glitch_pulse(1'b0);
    chk("glitch after clr", 32'(glitch_cnt), 32'd1);

    // reset asserted during QUALIFY
    pad_in = 1'b0; thresh = 8'd3;
    step(3);
    chk("rstq busy_pre", 32'(busy), 32'd1);
    rst = 1'b1; glitch_clr = 1'b0;
    step(1);
    chk("rstq level", 32'(level), 32'd0);
    chk("rstq busy", 32'(busy), 32'd0);
    chk("rstq fall", 32'(fall), 32'd0);
    chk("rstq rise", 32'(rise), 32'd0);
    chk("rstq glitch", 32'(glitch_cnt), 32'd0);
    rst = 1'b0;
    step(6);
    chk("post rst level", 32'(level), 32'd0);
    chk("post rst glitch", 32'(glitch_cnt), 32'd0);
    chk("post rst busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
